// File: rtl/tl_pkg.sv
// Shared types for the traffic-light safety monitor: signal-head codes,
// fault codes and the approach count.
package tl_pkg;

    localparam int NUM_APPR = 4;

    typedef enum logic [1:0] {
        TL_RED     = 2'b00,
        TL_YELLOW  = 2'b01,
        TL_GREEN   = 2'b10,
        TL_INVALID = 2'b11
    } tl_code_e;

    typedef enum logic [2:0] {
        F_NONE      = 3'd0,
        F_INVALID   = 3'd1,
        F_CONFLICT  = 3'd2,
        F_SEQ       = 3'd3,
        F_YEL_SHORT = 3'd4,
        F_GRN_LONG  = 3'd5,
        F_ALLRED    = 3'd6
    } fault_e;

    // YELLOW or GREEN: the approach currently holds right-of-way.
    function automatic logic is_lit(input tl_code_e c);
        return (c == TL_YELLOW) || (c == TL_GREEN);
    endfunction

endpackage

// File: rtl/tl_approach_tracker.sv
// Per-approach history: previous code, dwell counter and timed flag, plus the
// sequence and timing checks that depend on them.
module tl_approach_tracker
    import tl_pkg::*;
#(
    parameter int GREEN_MAX   = 20,
    parameter int YELLOW_TIME = 5,
    parameter int CNT_W       = 8
) (
    input  logic     clk,
    input  logic     rst,
    input  tl_code_e code_i,
    input  logic     clr_i,
    output logic     seq_err_o,
    output logic     yel_short_o,
    output logic     grn_long_o,
    output logic     red_to_green_o
);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] YEL_T   = CNT_W'(YELLOW_TIME);
    localparam logic [CNT_W-1:0] GRN_T   = CNT_W'(GREEN_MAX);

    tl_code_e         prev_q, prev_d;
    logic             valid_q, valid_d;
    logic             timed_q, timed_d;
    logic [CNT_W-1:0] dwell_q, dwell_d;
    logic             changed;

    always_comb begin
        // NOTE: every _d gets a default first so no path can infer a latch.
        changed = valid_q && (code_i != prev_q);
        prev_d  = code_i;
        valid_d = 1'b1;
        timed_d = timed_q | changed;
        dwell_d = dwell_q;
        if (!valid_q || changed) begin
            dwell_d = CNT_W'(1);
        end else if (dwell_q != CNT_MAX) begin
            dwell_d = dwell_q + 1'b1;
        end
        if (clr_i) begin
            prev_d  = TL_RED;
            valid_d = 1'b0;
            timed_d = 1'b0;
            dwell_d = '0;
        end
    end

    always_comb begin
        seq_err_o = valid_q && (((prev_q == TL_GREEN)  && (code_i == TL_RED))    ||
                                ((prev_q == TL_RED)    && (code_i == TL_YELLOW)) ||
                                ((prev_q == TL_YELLOW) && (code_i == TL_GREEN)));
        yel_short_o = valid_q && timed_q && (prev_q == TL_YELLOW) &&
                      (code_i == TL_RED) && (dwell_q < YEL_T);
        grn_long_o  = valid_q && timed_q && (prev_q == TL_GREEN) &&
                      (code_i == TL_GREEN) && (dwell_q == GRN_T);
        red_to_green_o = valid_q && (prev_q == TL_RED) && (code_i == TL_GREEN);
    end

    always_ff @(posedge clk) begin
        // NOTE: state uses non-blocking assignments so all registers update together.
        if (rst) begin
            prev_q  <= TL_RED;
            valid_q <= 1'b0;
            timed_q <= 1'b0;
            dwell_q <= '0;
        end else begin
            prev_q  <= prev_d;
            valid_q <= valid_d;
            timed_q <= timed_d;
            dwell_q <= dwell_d;
        end
    end

    // Long-green must be reachable before the dwell counter saturates.
    always_ff @(posedge clk) begin
        if (!rst) assert (GREEN_MAX + 1 < (2 ** CNT_W) - 1);
    end

endmodule

// File: rtl/tl_safety_monitor.sv
// Safety monitor for four signal heads: latches the first rule violation and
// requests flash mode. TL_MONITOR_ALLRED_CHECK_EN enables the all-red buffer check.
module tl_safety_monitor
    import tl_pkg::*;
#(
    parameter int GREEN_MAX   = 20,
    parameter int YELLOW_TIME = 5,
    parameter int RED_BUFFER  = 3,
    parameter int CNT_W       = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [1:0] TL1,
    input  logic [1:0] TL2,
    input  logic [1:0] TL3,
    input  logic [1:0] TL4,
    input  logic       fault_clr,
    output logic       fault,
    output logic [2:0] fault_code,
    output logic [1:0] fault_src,
    output logic       flash_mode,
    output logic [7:0] fault_count
);

    tl_code_e            tl [NUM_APPR];
    logic [NUM_APPR-1:0] seq_err, yel_short, grn_long, red_to_green, allred_err;
    logic [NUM_APPR-1:0] lit;

    assign tl[0] = tl_code_e'(TL1);
    assign tl[1] = tl_code_e'(TL2);
    assign tl[2] = tl_code_e'(TL3);
    assign tl[3] = tl_code_e'(TL4);

    for (genvar i = 0; i < NUM_APPR; i++) begin : g_trk
        tl_approach_tracker #(
            .GREEN_MAX  (GREEN_MAX),
            .YELLOW_TIME(YELLOW_TIME),
            .CNT_W      (CNT_W)
        ) u_trk (
            .clk           (clk),
            .rst           (rst),
            .code_i        (tl[i]),
            .clr_i         (fault_clr),
            .seq_err_o     (seq_err[i]),
            .yel_short_o   (yel_short[i]),
            .grn_long_o    (grn_long[i]),
            .red_to_green_o(red_to_green[i])
        );
        assign lit[i] = is_lit(tl[i]);
    end

`ifdef TL_MONITOR_ALLRED_CHECK_EN
    localparam logic [CNT_W-1:0] AR_MAX = '1;
    localparam logic [CNT_W-1:0] AR_MIN = CNT_W'(RED_BUFFER);

    logic [CNT_W-1:0] allred_cnt_q, allred_cnt_d;
    logic             seen_nonred_q, seen_nonred_d;
    logic             armed_q, armed_d;
    logic             all_red;

    always_comb begin
        all_red = (tl[0] == TL_RED) && (tl[1] == TL_RED) &&
                  (tl[2] == TL_RED) && (tl[3] == TL_RED);
        allred_cnt_d = '0;
        if (all_red) begin
            allred_cnt_d = (allred_cnt_q == AR_MAX) ? allred_cnt_q : allred_cnt_q + 1'b1;
        end
        seen_nonred_d = seen_nonred_q | ~all_red;
        // Armed once an all-red sample follows any non-red sample.
        armed_d       = armed_q | (seen_nonred_q & all_red);
        if (fault_clr) begin
            allred_cnt_d  = '0;
            seen_nonred_d = 1'b0;
            armed_d       = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            allred_cnt_q  <= '0;
            seen_nonred_q <= 1'b0;
            armed_q       <= 1'b0;
        end else begin
            allred_cnt_q  <= allred_cnt_d;
            seen_nonred_q <= seen_nonred_d;
            armed_q       <= armed_d;
        end
    end

    assign allred_err = (armed_q && (allred_cnt_q < AR_MIN)) ? red_to_green : '0;
`else
    logic unused_allred;
    assign unused_allred = ^{red_to_green, RED_BUFFER[0]};
    assign allred_err    = '0;
`endif

    fault_e     det_code;
    logic [1:0] det_src;

    // Scan from lowest priority up so the lowest code and lowest index win.
    always_comb begin
        det_code = F_NONE;
        det_src  = '0;
        if (!fault_clr) begin
            for (int i = NUM_APPR - 1; i >= 0; i--)
                if (allred_err[i]) begin det_code = F_ALLRED;    det_src = 2'(i); end
            for (int i = NUM_APPR - 1; i >= 0; i--)
                if (grn_long[i])   begin det_code = F_GRN_LONG;  det_src = 2'(i); end
            for (int i = NUM_APPR - 1; i >= 0; i--)
                if (yel_short[i])  begin det_code = F_YEL_SHORT; det_src = 2'(i); end
            for (int i = NUM_APPR - 1; i >= 0; i--)
                if (seq_err[i])    begin det_code = F_SEQ;       det_src = 2'(i); end
        end
        if ($countones(lit) >= 2) begin
            for (int i = NUM_APPR - 1; i >= 0; i--)
                if (lit[i]) begin det_code = F_CONFLICT; det_src = 2'(i); end
        end
        for (int i = NUM_APPR - 1; i >= 0; i--)
            if (tl[i] == TL_INVALID) begin det_code = F_INVALID; det_src = 2'(i); end
    end

    logic       fault_q, fault_d;
    fault_e     fault_code_q, fault_code_d;
    logic [1:0] fault_src_q, fault_src_d;
    logic [7:0] fault_count_q, fault_count_d;

    always_comb begin
        fault_d       = fault_q;
        fault_code_d  = fault_code_q;
        fault_src_d   = fault_src_q;
        fault_count_d = fault_count_q;
        if ((det_code != F_NONE) && (!fault_q || fault_clr)) begin
            fault_d      = 1'b1;
            fault_code_d = det_code;
            fault_src_d  = det_src;
            if (fault_count_q != 8'hFF) fault_count_d = fault_count_q + 8'd1;
        end else if (fault_clr) begin
            fault_d      = 1'b0;
            fault_code_d = F_NONE;
            fault_src_d  = '0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            fault_q       <= 1'b0;
            fault_code_q  <= F_NONE;
            fault_src_q   <= '0;
            fault_count_q <= '0;
        end else begin
            fault_q       <= fault_d;
            fault_code_q  <= fault_code_d;
            fault_src_q   <= fault_src_d;
            fault_count_q <= fault_count_d;
        end
    end

    assign fault       = fault_q;
    assign flash_mode  = fault_q;
    assign fault_code  = fault_code_q;
    assign fault_src   = fault_src_q;
    assign fault_count = fault_count_q;

endmodule
